multi_timer: RTL and testbench
==============================

MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels, 1..8.
REQ-002 Parameter WIDTH, default 32: counter and PRESET width, 8..32; narrower values zero-extend on Dout.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 Addr  input  [31:2]  word address; Addr[3:2] selects register, Addr[6:4] selects channel.
REQ-006 WE  input  1  write strobe for the addressed register.
REQ-007 Din  input  32  write data.
REQ-008 Dout  output  32  combinational read data of the addressed register.
REQ-009 IRQ  output  1  OR over all channels of (PENDING & IM).
REQ-010 irq_vec  output  NUM_CH  per-channel (PENDING & IM).

Function
REQ-011 Per-channel register map SHALL be: offset 0 CTRL; offset 1 PRESET; offset 2 COUNT (read-only); offset 3 STATUS.
- CTRL[0]=EN, CTRL[2:1]=MODE, CTRL[3]=IM; other bits write-ignored, read 0.
- STATUS[0]=PENDING, write-1-to-clear; other bits read 0.
REQ-012 Channel index >= NUM_CH SHALL read 0 and ignore writes.
REQ-013 A write SHALL affect only the addressed register; all channels, including the addressed one, keep counting in that cycle.
REQ-014 Each channel SHALL run FSM IDLE/LOAD/CNT/INT, resetting to IDLE.
REQ-015 IDLE: EN=1 -> LOAD.
REQ-016 LOAD: COUNT<=PRESET -> CNT.
REQ-017 CNT with EN=0 -> IDLE, COUNT holds.
REQ-018 CNT with EN=1: if COUNT>1, COUNT<=COUNT-1; else COUNT<=0, PENDING<=1, -> INT.
REQ-019 INT: MODE=00 (one-shot) clears EN and goes to IDLE.
REQ-020 INT: MODE=01 (auto-reload) goes to LOAD directly, giving period PRESET+2 cycles.
REQ-021 INT: MODE=10 (periodic-hold) goes to IDLE, keeps EN, and re-arms only after PENDING is cleared.
REQ-022 INT: MODE=11 SHALL behave as 00.
REQ-023 PRESET=0 SHALL behave as PRESET=1.
REQ-024 Writing PRESET SHALL NOT change COUNT until the next LOAD.
REQ-025 A CTRL write with EN=0 SHALL take effect at the next FSM step; a one-shot EN clear from INT in the same cycle as a CTRL write SHALL yield the written value.
REQ-026 Hardware PENDING set and a W1C in the same cycle SHALL leave PENDING=1.
REQ-027 PENDING SHALL be sticky regardless of IM; IM gates IRQ/irq_vec only.

Reset
REQ-028 On reset, every CTRL, PRESET, COUNT and PENDING SHALL be 0 and every FSM in IDLE.
REQ-029 After reset, IRQ and irq_vec SHALL be 0 and Dout SHALL reflect zeroed registers.
REQ-030 Reset SHALL override WE and any in-progress count.

Verification
REQ-031 One-shot: ch0 PRESET=5, CTRL=0x9 written at edge 0 -> COUNT=5 after edge 2; PENDING, IRQ, irq_vec[0]=1 after edge 7; CTRL=0x8 after edge 8.
REQ-032 Auto-reload: ch1 PRESET=3, CTRL=0xB -> PENDING asserts every 5 cycles; W1C between pulses drops IRQ until the next expiry.
REQ-033 Write collision: a write to ch2 PRESET while ch0 counts -> ch0 COUNT still decrements each cycle; same-cycle expiry and W1C leaves PENDING=1.
REQ-034 Periodic-hold: ch3 MODE=10, PRESET=2 -> after the first expiry COUNT stays 0 until STATUS W1C, then reloads.
REQ-035 Address bounds: with NUM_CH=4, writing channel 5 CTRL=0x1 -> no state change and reads return 0.
REQ-036 Mid-count reset: assert reset with ch0 COUNT=100 -> all registers 0 and IRQ=0 on the next edge.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer block with memory-mapped registers.
// Each channel has CTRL/PRESET/COUNT/STATUS and an IDLE/LOAD/CNT/INT sequencer.
module multi_timer #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:2]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic              IRQ,
    output logic [NUM_CH-1:0] irq_vec
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_PRESET  = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;
    localparam logic [1:0] MODE_RELOAD = 2'b01;
    localparam logic [1:0] MODE_HOLD   = 2'b10;

    logic [2:0]                ch_sel;
    logic [1:0]                reg_sel;
    logic [NUM_CH-1:0][31:0]   rd_data;
    logic                      unused_bits;

    assign ch_sel      = Addr[6:4];
    assign reg_sel     = Addr[3:2];
    assign unused_bits = ^{Addr[31:7], Din};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t           state_q, state_d;
        logic             en_q, en_d;
        logic [1:0]       mode_q;
        logic             im_q;
        logic [WIDTH-1:0] preset_q;
        logic [WIDTH-1:0] count_q, count_d;
        logic             pending_q;
        logic             set_pend;
        logic             sel, wr;
        logic             wr_ctrl, wr_preset, wr_clr;
        logic [31:0]      rd;

        // Channels beyond NUM_CH never match, so they read 0 and ignore writes
        assign sel       = (ch_sel == 3'(i));
        assign wr        = WE && sel;
        assign wr_ctrl   = wr && (reg_sel == REG_CTRL);
        assign wr_preset = wr && (reg_sel == REG_PRESET);
        assign wr_clr    = wr && (reg_sel == REG_STATUS) && Din[0];

        always_comb begin
            state_d  = state_q;
            en_d     = en_q;
            count_d  = count_q;
            set_pend = 1'b0;
            unique case (state_q)
                IDLE: begin
                    // Periodic-hold stays parked until software clears PENDING
                    if (en_q && !(mode_q == MODE_HOLD && pending_q))
                        state_d = LOAD;
                end
                LOAD: begin
                    count_d = (preset_q == '0) ? WIDTH'(1) : preset_q;
                    state_d = CNT;
                end
                CNT: begin
                    if (!en_q) begin
                        state_d = IDLE;
                    end else if (count_q > WIDTH'(1)) begin
                        count_d = count_q - WIDTH'(1);
                    end else begin
                        count_d  = '0;
                        set_pend = 1'b1;
                        state_d  = INT;
                    end
                end
                INT: begin
                    state_d = IDLE;
                    if (mode_q == MODE_RELOAD)
                        state_d = LOAD;
                    else if (mode_q != MODE_HOLD)
                        en_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q   <= IDLE;
                en_q      <= 1'b0;
                mode_q    <= 2'b00;
                im_q      <= 1'b0;
                preset_q  <= '0;
                count_q   <= '0;
                pending_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                // Software write wins over the one-shot EN clear
                en_q      <= wr_ctrl ? Din[0] : en_d;
                if (wr_ctrl) begin
                    mode_q <= Din[2:1];
                    im_q   <= Din[3];
                end
                if (wr_preset)
                    preset_q <= Din[WIDTH-1:0];
                pending_q <= set_pend | (pending_q & ~wr_clr);
            end
        end

        always_comb begin
            rd = '0;
            if (sel) begin
                unique case (reg_sel)
                    REG_CTRL:   rd = {28'b0, im_q, mode_q, en_q};
                    REG_PRESET: rd = 32'(preset_q);
                    REG_COUNT:  rd = 32'(count_q);
                    REG_STATUS: rd = {31'b0, pending_q};
                endcase
            end
        end

        assign rd_data[i] = rd;
        assign irq_vec[i] = pending_q & im_q;
    end

    always_comb begin
        Dout = '0;
        for (int i = 0; i < NUM_CH; i++)
            Dout = Dout | rd_data[i];
    end

    assign IRQ = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus a
// randomized register-traffic run against a behavioural channel model.
module tb_multi_timer;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 32;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:2] Addr = '0;
    logic        WE = 1'b0;
    logic [31:0] Din = '0;
    logic [31:0] Dout;
    logic        IRQ;
    logic [NUM_CH-1:0] irq_vec;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit          m_en   [NUM_CH];
    bit [1:0]    m_mode [NUM_CH];
    bit          m_im   [NUM_CH];
    int unsigned m_pre  [NUM_CH];
    int unsigned m_cnt  [NUM_CH];
    bit          m_pend [NUM_CH];
    int          m_ph   [NUM_CH];

    multi_timer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .IRQ     (IRQ),
        .irq_vec (irq_vec)
    );

    always #50 clk = ~clk;

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0;
            m_pre[c] = 0; m_cnt[c] = 0; m_pend[c] = 0;
            m_ph[c] = PH_IDLE;
        end
    endfunction

    function automatic void model_step(bit we, int wch, int wr,
                                       logic [31:0] din);
        for (int c = 0; c < NUM_CH; c++) begin
            bit hw = 0;
            case (m_ph[c])
                PH_IDLE:
                    if (m_en[c] && !(m_mode[c] == 2 && m_pend[c]))
                        m_ph[c] = PH_LOAD;
                PH_LOAD: begin
                    m_cnt[c] = (m_pre[c] == 0) ? 1 : m_pre[c];
                    m_ph[c] = PH_CNT;
                end
                PH_CNT:
                    if (!m_en[c]) m_ph[c] = PH_IDLE;
                    else if (m_cnt[c] > 1) m_cnt[c] = m_cnt[c] - 1;
                    else begin
                        m_cnt[c] = 0; hw = 1; m_ph[c] = PH_INT;
                    end
                default: begin
                    if (m_mode[c] == 1) m_ph[c] = PH_LOAD;
                    else begin
                        m_ph[c] = PH_IDLE;
                        if (m_mode[c] != 2) m_en[c] = 0;
                    end
                end
            endcase
            if (we && wch == c) begin
                case (wr)
                    0: begin
                        m_en[c] = din[0]; m_mode[c] = din[2:1];
                        m_im[c] = din[3];
                    end
                    1: m_pre[c] = din;
                    3: if (din[0]) m_pend[c] = 0;
                    default: ;
                endcase
            end
            if (hw) m_pend[c] = 1;
        end
    endfunction

    function automatic logic [31:0] exp_rd(int c, int r);
        if (c >= NUM_CH) return 32'h0;
        case (r)
            0: return {28'b0, m_im[c], m_mode[c], m_en[c]};
            1: return m_pre[c];
            2: return m_cnt[c];
            default: return {31'b0, m_pend[c]};
        endcase
    endfunction

    function automatic logic [NUM_CH-1:0] exp_vec();
        logic [NUM_CH-1:0] v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pend[c] & m_im[c];
        return v;
    endfunction

    task automatic tick(input bit we, input int ch, input int r,
                        input logic [31:0] din,
                        input logic [24:0] hi = '0);
        Addr = {hi, 3'(ch), 2'(r)};
        WE = we;
        Din = din;
        @(posedge clk);
        cyc++;
        if (reset) model_reset();
        else model_step(we, ch, r, din);
        #1;
        WE = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
    endtask

    task automatic rd(input int ch, input int r, output logic [31:0] v);
        Addr = {25'b0, 3'(ch), 2'(r)};
        WE = 1'b0;
        #1;
        v = Dout;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                checks++;
                if (v !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_reg ch%0d r%0d: got %h want 0", c, r, v);
                end
            end
        checks++;
        if (IRQ !== 1'b0 || irq_vec !== '0) begin
            failures++;
            $display("FAIL reset_irq: got %b/%b want 0/0", IRQ, irq_vec);
        end
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        do_reset();
        tick(1, 0, 1, 5);
        tick(1, 0, 0, 32'h9);
        idle(2);
        rd(0, 2, v);
        checks++;
        if (v !== 32'd5) begin
            failures++;
            $display("FAIL oneshot_load: got %0d want 5", v);
        end
        idle(4);
        rd(0, 2, v);
        checks++;
        if (v !== 32'd1 || IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_edge6: got cnt=%0d irq=%b want 1/0", v, IRQ);
        end
        idle(1);
        rd(0, 3, v);
        checks++;
        if (v !== 32'd1 || IRQ !== 1'b1 || irq_vec !== 4'b0001) begin
            failures++;
            $display("FAIL oneshot_expire: got pend=%0d irq=%b vec=%b want 1/1/0001",
                     v, IRQ, irq_vec);
        end
        idle(1);
        rd(0, 0, v);
        checks++;
        if (v !== 32'h8) begin
            failures++;
            $display("FAIL oneshot_ctrl: got %h want 8", v);
        end
        idle(3);
        rd(0, 2, v);
        checks++;
        if (v !== 32'd0 || IRQ !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_stopped: got cnt=%0d irq=%b want 0/1", v, IRQ);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        int prev, t;
        bit found;
        do_reset();
        tick(1, 1, 1, 3);
        tick(1, 1, 0, 32'hB);
        prev = cyc;
        for (int p = 0; p < 3; p++) begin
            found = 0;
            t = 0;
            for (int k = 0; k < 12 && !found; k++) begin
                tick(0, 0, 0, 0);
                rd(1, 3, v);
                if (v[0]) begin
                    found = 1;
                    t = cyc;
                end
            end
            checks++;
            if (!found || t - prev != 5 || IRQ !== 1'b1 || irq_vec !== 4'b0010) begin
                failures++;
                $display("FAIL reload_period%0d: got found=%0d dt=%0d irq=%b vec=%b want 1/5/1/0010",
                         p, found, t - prev, IRQ, irq_vec);
            end
            prev = t;
            tick(1, 1, 3, 1);
            rd(1, 3, v);
            checks++;
            if (v !== 32'd0 || IRQ !== 1'b0) begin
                failures++;
                $display("FAIL reload_w1c%0d: got pend=%0d irq=%b want 0/0", p, v, IRQ);
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] v, w;
        do_reset();
        tick(1, 0, 1, 4);
        tick(1, 0, 0, 32'h9);
        idle(2);
        tick(1, 2, 1, 32'h55);
        rd(0, 2, v);
        rd(2, 1, w);
        checks++;
        if (v !== 32'd3 || w !== 32'h55) begin
            failures++;
            $display("FAIL collide_preset: got cnt=%0d pre=%h want 3/55", v, w);
        end
        for (int e = 2; e >= 1; e--) begin
            tick(1, 2, 1, 32'h66 + e);
            rd(0, 2, v);
            checks++;
            if (v !== 32'(e)) begin
                failures++;
                $display("FAIL collide_count: got %0d want %0d", v, e);
            end
        end
        tick(1, 0, 3, 1);
        rd(0, 3, v);
        checks++;
        if (v !== 32'd1 || IRQ !== 1'b1) begin
            failures++;
            $display("FAIL collide_w1c: got pend=%0d irq=%b want 1/1", v, IRQ);
        end
        tick(1, 0, 0, 32'h9);
        rd(0, 0, v);
        checks++;
        if (v !== 32'h9) begin
            failures++;
            $display("FAIL collide_ctrl: got %h want 9", v);
        end
    endtask

    task automatic test_periodic_hold();
        logic [31:0] v, w;
        do_reset();
        tick(1, 3, 1, 2);
        tick(1, 3, 0, 32'h5);
        idle(4);
        rd(3, 3, v);
        rd(3, 2, w);
        checks++;
        if (v !== 32'd1 || w !== 32'd0 || IRQ !== 1'b0 || irq_vec !== '0) begin
            failures++;
            $display("FAIL hold_expire: got pend=%0d cnt=%0d irq=%b vec=%b want 1/0/0/0000",
                     v, w, IRQ, irq_vec);
        end
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 0, 0);
            rd(3, 2, v);
            rd(3, 0, w);
            checks++;
            if (v !== 32'd0 || w !== 32'h5) begin
                failures++;
                $display("FAIL hold_parked: got cnt=%0d ctrl=%h want 0/5", v, w);
            end
        end
        tick(1, 3, 3, 1);
        idle(1);
        rd(3, 2, v);
        checks++;
        if (v !== 32'd0) begin
            failures++;
            $display("FAIL hold_rearm_wait: got %0d want 0", v);
        end
        idle(1);
        rd(3, 2, v);
        checks++;
        if (v !== 32'd2) begin
            failures++;
            $display("FAIL hold_reload: got %0d want 2", v);
        end
    endtask

    task automatic test_addr_bounds();
        logic [31:0] v;
        do_reset();
        tick(1, 5, 0, 32'h1);
        tick(1, 5, 1, 32'h3);
        tick(1, 7, 0, 32'hF);
        idle(5);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                checks++;
                if (v !== 32'h0) begin
                    failures++;
                    $display("FAIL bounds ch%0d r%0d: got %h want 0", c, r, v);
                end
            end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL bounds_irq: got %b want 0", IRQ);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        bit found = 0;
        do_reset();
        tick(1, 0, 1, 200);
        tick(1, 1, 1, 1);
        tick(1, 1, 0, 32'h9);
        tick(1, 0, 0, 32'h9);
        for (int k = 0; k < 300 && !found; k++) begin
            tick(0, 0, 0, 0);
            rd(0, 2, v);
            if (v == 32'd100) found = 1;
        end
        checks++;
        if (!found || IRQ !== 1'b1) begin
            failures++;
            $display("FAIL midrst_setup: got found=%0d irq=%b want 1/1", found, IRQ);
        end
        reset = 1'b1;
        tick(1, 0, 0, 32'hF);
        reset = 1'b0;
        for (int c = 0; c < NUM_CH; c++)
            for (int r = 0; r < 4; r++) begin
                rd(c, r, v);
                checks++;
                if (v !== 32'h0) begin
                    failures++;
                    $display("FAIL midrst ch%0d r%0d: got %h want 0", c, r, v);
                end
            end
        checks++;
        if (IRQ !== 1'b0 || irq_vec !== '0) begin
            failures++;
            $display("FAIL midrst_irq: got %b/%b want 0/0", IRQ, irq_vec);
        end
    endtask

    task automatic test_random();
        logic [31:0] v, e, din;
        int ch, r;
        bit we;
        do_reset();
        for (int n = 0; n < 500; n++) begin
            we = ($urandom_range(0, 2) == 0);
            ch = $urandom_range(0, 5);
            r = $urandom_range(0, 3);
            din = $urandom;
            if (r == 1) din = $urandom_range(0, 6);
            if (r == 0) din[0] = ($urandom_range(0, 3) != 0);
            tick(we, ch, r, din, 25'($urandom));
            for (int c = 0; c < 8; c++)
                for (int q = 0; q < 4; q++) begin
                    rd(c, q, v);
                    e = exp_rd(c, q);
                    checks++;
                    if (v !== e) begin
                        failures++;
                        $display("FAIL rand_reg cyc%0d ch%0d r%0d: got %h want %h",
                                 n, c, q, v, e);
                    end
                end
            checks++;
            if (irq_vec !== exp_vec() || IRQ !== (|exp_vec())) begin
                failures++;
                $display("FAIL rand_irq cyc%0d: got %b/%b want %b/%b",
                         n, IRQ, irq_vec, |exp_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_collision();
        test_periodic_hold();
        test_addr_bounds();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
